// File: rtl/mux_out_fifo.sv
// Capture FIFO behind the 4:1 mux: no backpressure on input, FWFT valid/ready output.
// Words that arrive while the FIFO is full are dropped, counted (saturating) and flagged.
module mux_out_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    input  logic              clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              push_ok, pop, drop;

    // Status comes only from registered state; no path from in_valid/out_ready.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr_q];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    assign pop     = out_valid && out_ready;
    assign push_ok = in_valid && (!full || pop);
    assign drop    = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        // Clear wins for the counter, but a same-cycle drop still sets the sticky flag.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (clr_ovf) begin
            drop_cnt_d = 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_mux_out_fifo.sv
// Directed self-checking bench for mux_out_fifo (DATA_W=8, DEPTH=8).
module tb_mux_out_fifo;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf;

    int total;
    int bad;

    mux_out_fifo #(
        .DATA_W(8),
        .DEPTH (8),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic fill_0_to_7();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        step();
        step();
        total++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 ||
            overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_vals: got ov=%b em=%b fu=%b cnt=%0d ovf=%b drop=%0d, want 0 1 0 0 0 0",
                     out_valid, empty, full, count, overflow, drop_cnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_push();
        in_valid = 1'b1;
        in_data  = 8'h11;
        step();
        in_data = 8'h22;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || count !== 4'd1) begin
            bad++;
            $display("FAIL first_word_latency: got ov=%b data=%h cnt=%0d, want 1 11 1",
                     out_valid, out_data, count);
        end
        step();
        in_data = 8'h33;
        step();
        in_valid = 1'b0;
        total++;
        if (count !== 4'd3 || out_data !== 8'h11 || empty !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL three_push: got cnt=%0d data=%h em=%b fu=%b, want 3 11 0 0",
                     count, out_data, empty, full);
        end
    endtask

    task automatic test_overflow_drain();
        apply_reset();
        fill_0_to_7();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hF0 + i);
            step();
        end
        in_valid = 1'b0;
        total++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd3) begin
            bad++;
            $display("FAIL overflow_status: got fu=%b cnt=%0d ovf=%b drop=%0d, want 1 8 1 3",
                     full, count, overflow, drop_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                bad++;
                $display("FAIL drain_order[%0d]: got ov=%b data=%h, want 1 %h",
                         i, out_valid, out_data, 8'(i));
            end
            step();
        end
        out_ready = 1'b0;
        total++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            bad++;
            $display("FAIL drain_empty: got em=%b cnt=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        apply_reset();
        fill_0_to_7();
        for (int i = 0; i < 8; i++) q.push_back(8'(i));
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(8'hA0 + i);
            out_ready = 1'b1;
            total++;
            if (out_data !== q[0]) begin
                bad++;
                $display("FAIL b2b_data[%0d]: got %h, want %h", i, out_data, q[0]);
            end
            step();
            void'(q.pop_front());
            q.push_back(8'(8'hA0 + i));
            total++;
            if (count !== 4'd8 || drop_cnt !== 8'd0) begin
                bad++;
                $display("FAIL b2b_count[%0d]: got cnt=%0d drop=%0d, want 8 0", i, count, drop_cnt);
            end
        end
        in_valid = 1'b0;
        while (q.size() > 0) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== q[0]) begin
                bad++;
                $display("FAIL b2b_drain: got ov=%b data=%h, want 1 %h", out_valid, out_data, q[0]);
            end
            step();
            void'(q.pop_front());
        end
        out_ready = 1'b0;
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_empty: got em=%b, want 1", empty);
        end
    endtask

    task automatic test_empty_push_ready();
        apply_reset();
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_no_pop: got ov=%b, want 0", out_valid);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 4'd1) begin
            bad++;
            $display("FAIL empty_push_ready: got ov=%b data=%h cnt=%0d, want 1 5a 1",
                     out_valid, out_data, count);
        end
    endtask

    task automatic test_drop_saturate_clear();
        apply_reset();
        fill_0_to_7();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        total++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 4'd8) begin
            bad++;
            $display("FAIL drop_saturate: got drop=%0d ovf=%b cnt=%0d, want 255 1 8",
                     drop_cnt, overflow, count);
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL clear_ovf: got ovf=%b drop=%0d, want 0 0", overflow, drop_cnt);
        end
        in_valid = 1'b1;
        clr_ovf  = 1'b1;
        step();
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        total++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd0 || count !== 4'd8) begin
            bad++;
            $display("FAIL clear_with_drop: got ovf=%b drop=%0d cnt=%0d, want 1 0 8",
                     overflow, drop_cnt, count);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            step();
        end
        in_valid = 1'b0;
        total++;
        if (count !== 4'd5) begin
            bad++;
            $display("FAIL pre_reset_count: got %0d, want 5", count);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 ||
            overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got ov=%b em=%b fu=%b cnt=%0d ovf=%b drop=%0d, want 0 1 0 0 0 0",
                     out_valid, empty, full, count, overflow, drop_cnt);
        end
        step();
        #2;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        total++;
        if (count !== 4'd1 || out_valid !== 1'b1 || out_data !== 8'h77) begin
            bad++;
            $display("FAIL post_reset_push: got cnt=%0d ov=%b data=%h, want 1 1 77",
                     count, out_valid, out_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_push();
        test_overflow_drain();
        test_back_to_back();
        test_empty_push_ready();
        test_drop_saturate_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
